// File: rtl/part3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | part3_pkg : shared encodings and defaults for the part3 divider      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package part3_pkg;

  localparam int c_DW_DEFAULT = 8;
  localparam int c_VW_DEFAULT = 4;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_RUN  = c_ST_RUN,
    ST_DONE = c_ST_DONE
  } state_t;

  localparam logic [c_DW_DEFAULT-1:0] c_DZ_QUOTIENT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/part3_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | part3_div_step : one restoring shift-subtract iteration              |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module part3_div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   i_p,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW:0]   o_p,
  output logic          o_q
);

  logic [VW+1:0] w_shift;

  always_comb begin
    w_shift = {i_p, i_bit};
    o_q     = (w_shift >= {2'b00, i_divisor});
    // The difference always fits VW+1 bits because P stays below the divisor.
    o_p     = o_q ? (w_shift[VW:0] - {1'b0, i_divisor}) : w_shift[VW:0];
  end

endmodule
`default_nettype wire

// File: rtl/part3_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | part3_divider : sequential restoring divider, DW/VW -> quotient/rem  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module part3_divider
  import part3_pkg::*;
#(
  parameter int DW = c_DW_DEFAULT,
  parameter int VW = c_VW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_quotient,
  output logic [VW-1:0] o_remainder,
  output logic          o_div_by_zero
);

  localparam int            CW     = $clog2(DW) + 1;
  localparam logic [CW-1:0] c_LAST = CW'(DW - 1);
  localparam logic [DW-1:0] c_DZ_Q = {DW{c_DZ_QUOTIENT[0]}};

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_work;
  logic [VW-1:0] r_dvs;
  logic [VW:0]   r_p;
  logic          r_zpend;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  logic          r_dz;

  logic          w_accept;
  logic          w_last;
  logic          w_dvs_zero;
  logic [VW:0]   w_p_next;
  logic          w_q;

  part3_div_step #(
    .VW (VW)
  ) u_step (
    .i_p       (r_p),
    .i_bit     (r_work[DW-1]),
    .i_divisor (r_dvs),
    .o_p       (w_p_next),
    .o_q       (w_q)
  );

  // A zero divisor is accepted, then posts its result one edge later without RUN.
  assign w_dvs_zero = (i_divisor == '0);
  assign w_accept   = i_start && !r_zpend && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_state == ST_RUN) && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_zpend) begin
          w_next = ST_DONE;
        end else if (i_start && !w_dvs_zero) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start && !w_dvs_zero) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_work  <= '0;
      r_dvs   <= '0;
      r_p     <= '0;
      r_zpend <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_zpend <= w_accept && w_dvs_zero;

      if (w_accept) begin
        r_work <= i_dividend;
        r_dvs  <= i_divisor;
        r_p    <= '0;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        // Dividend bits leave at the MSB while quotient bits enter at the LSB.
        r_work <= {r_work[DW-2:0], w_q};
        r_p    <= w_p_next;
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_last) begin
        r_quot <= {r_work[DW-2:0], w_q};
        r_rem  <= w_p_next[VW-1:0];
        r_dz   <= 1'b0;
      end else if (r_zpend) begin
        r_quot <= c_DZ_Q;
        r_rem  <= r_work[VW-1:0];
        r_dz   <= 1'b1;
      end
    end
  end

  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_part3_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_part3_divider : directed bench with a cycle-timeline model        |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_part3_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_dividend = '0;
  logic [VW-1:0] i_divisor = '0;
  logic          o_busy;
  logic          o_done;
  logic [DW-1:0] o_quotient;
  logic [VW-1:0] o_remainder;
  logic          o_div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_dones  = 0;

  part3_divider #(
    .DW (DW),
    .VW (VW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted operation finishes DW edges later (1 for a zero divisor);
  // results come straight from the arithmetic operators.
  int            m_left;
  logic          m_done, m_dz;
  logic [DW-1:0] m_q;
  logic [VW-1:0] m_r;
  logic [DW-1:0] p_q;
  logic [VW-1:0] p_r;
  logic          p_dz;
  logic          m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
      p_q    <= '0;
      p_r    <= '0;
      p_dz   <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_q  <= p_q;
        m_r  <= p_r;
        m_dz <= p_dz;
      end
      if (m_left == 0 && i_start) begin
        if (i_divisor == 0) begin
          m_left <= 1;
          p_q    <= 8'hFF;
          p_r    <= i_dividend[VW-1:0];
          p_dz   <= 1'b1;
        end else begin
          m_left <= DW;
          p_q    <= i_dividend / {4'b0, i_divisor};
          p_r    <= VW'(i_dividend % {4'b0, i_divisor});
          p_dz   <= 1'b0;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  assign m_busy = (m_left > 0) && !p_dz;

  always @(negedge clk) begin
    check("busy", 32'(o_busy), 32'(m_busy));
    check("done", 32'(o_done), 32'(m_done));
    check("quotient", 32'(o_quotient), 32'(m_q));
    check("remainder", 32'(o_remainder), 32'(m_r));
    check("div_by_zero", 32'(o_div_by_zero), 32'(m_dz));
    if (o_done) n_dones++;
  end

  // Caller is at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [3:0] b,
                        input int eq, input int er, input int edz, input int elat,
                        input int inj_at, input logic [7:0] ia, input logic [3:0] ib);
    int   n;
    logic saw_busy;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    n        = 0;
    saw_busy = o_busy;
    check({"busy_after_accept_", nm}, 32'(o_busy), 32'(b != 0));
    while (!o_done && n < 20) begin
      if (n == inj_at) begin
        i_dividend = ia;
        i_divisor  = ib;
        i_start    = 1'b1;
      end
      @(negedge clk);
      i_start = 1'b0;
      n++;
      if (o_busy) saw_busy = 1'b1;
    end
    if (!o_done) begin
      check({"timeout_", nm}, 32'(o_done), 32'd1);
    end else begin
      check({"latency_", nm}, n, elat);
      check({"lit_q_", nm}, 32'(o_quotient), eq);
      check({"lit_r_", nm}, 32'(o_remainder), er);
      check({"lit_dz_", nm}, 32'(o_div_by_zero), edz);
      if (b == 0) check({"busy_seen_", nm}, 32'(saw_busy), 32'd0);
    end
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(o_busy), 0);
    check("reset_done", 32'(o_done), 0);
    check("reset_q", 32'(o_quotient), 0);
    check("reset_r", 32'(o_remainder), 0);
    check("reset_dz", 32'(o_div_by_zero), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    run_op("200_7", 8'd200, 4'd7, 28, 4, 0, 8, -1, 8'd0, 4'd0);
    @(negedge clk);
    run_op("255_1", 8'd255, 4'd1, 255, 0, 0, 8, -1, 8'd0, 4'd0);
    @(negedge clk);
    run_op("5_9", 8'd5, 4'd9, 0, 5, 0, 8, -1, 8'd0, 4'd0);
    @(negedge clk);
    run_op("15_15", 8'd15, 4'd15, 1, 0, 0, 8, -1, 8'd0, 4'd0);
    @(negedge clk);
    run_op("100_0", 8'd100, 4'd0, 255, 4, 1, 1, -1, 8'd0, 4'd0);
    @(negedge clk);

    // start pulsed mid-run must be dropped entirely
    d0 = n_dones;
    run_op("busy_start", 8'd200, 4'd7, 28, 4, 0, 8, 3, 8'd10, 4'd3);
    repeat (12) @(negedge clk);
    check("one_done_busy_start", n_dones - d0, 1);
    check("q_held_busy_start", 32'(o_quotient), 28);

    // back-to-back: second start issued during the done cycle
    run_op("b2b_first", 8'd200, 4'd7, 28, 4, 0, 8, -1, 8'd0, 4'd0);
    run_op("b2b_second", 8'd15, 4'd15, 1, 0, 0, 8, -1, 8'd0, 4'd0);
    @(negedge clk);

    // asynchronous reset in the middle of RUN
    i_dividend = 8'd200;
    i_divisor  = 4'd7;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_q", 32'(o_quotient), 0);
    check("rst_r", 32'(o_remainder), 0);
    check("rst_dz", 32'(o_div_by_zero), 0);
    d0 = n_dones;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", n_dones - d0, 0);
    run_op("9_2", 8'd9, 4'd2, 4, 1, 0, 8, -1, 8'd0, 4'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
